wave_pwm_dac: RTL and testbench
===============================

WAVE_PWM_DAC -- requirements
Module: wave_pwm_dac

Interface
REQ-001 SHALL have parameter DIV_W, default 16, giving the prescaler width in bits.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port en, input, 1 bit: run request.
REQ-005 SHALL have port sample, input, 8 bits: unsigned waveform sample from the function-generator stage.
REQ-006 SHALL have port gain, input, 8 bits: unsigned amplitude scale (255 = unity).
REQ-007 SHALL have port offset, input, 8 bits: two's-complement DC offset, -128..+127.
REQ-008 SHALL have port prescale, input, DIV_W bits: PWM tick divider; one tick every prescale+1 clocks.
REQ-009 SHALL have port sat_clr, input, 1 bit: clears the sat flag.
REQ-010 SHALL have port pwm_out, output, 1 bit: PWM DAC output.
REQ-011 SHALL have port sample_req, output, 1 bit: one-cycle pulse when a new duty is captured.
REQ-012 SHALL have port busy, output, 1 bit: high whenever state is not IDLE.
REQ-013 SHALL have port sat, output, 1 bit: sticky flag for clamp at capture.

Function
REQ-014 SHALL register stage 1: prod = sample * (gain + 1), 16 bits; scaled = prod[15:8], giving a range of 0..255.
REQ-015 SHALL register stage 2: sum = zero-extended scaled + sign-extended offset, at 10 bits signed; clamp below 0 to 0 and above 255 to 255, giving next_duty; clamp_hit = clamp occurred.
REQ-016 SHALL have 2-cycle latency: sample/gain/offset stable at cycle t appear in next_duty/clamp_hit at t+2; the pipeline runs in every state.
REQ-017 SHALL implement FSM states IDLE, RUN, STOP.
REQ-018 SHALL, in IDLE: pwm_out=0, prescaler=0, phase=0; en=1 -> RUN.
REQ-019 SHALL define a period start as the RUN entry cycle, and as any tick where phase==254, with phase then wrapping to 0.
REQ-020 SHALL perform these actions at each period start: duty <= next_duty; prescale_q <= prescale; sample_req=1 for that cycle; sat set if clamp_hit.
REQ-021 SHALL generate a tick when prescaler==prescale_q; on a tick the prescaler goes to 0 and phase increments, otherwise the prescaler increments.
REQ-022 SHALL use a period of 255 ticks (phase 0..254): pwm_out = (phase < duty) in RUN/STOP, registered, so duty 0 = constant low and duty 255 = constant high.
REQ-023 SHALL treat prescale changes mid-period as taking effect only at the next period start.
REQ-024 SHALL, in RUN with en=0, go to STOP; the PWM continues unchanged.
REQ-025 SHALL, in STOP at the final tick of the period (phase==254), go to IDLE; no capture, no sample_req, and pwm_out=0 from the next cycle.
REQ-026 SHALL, in STOP with en=1, return to RUN with no phase or duty disturbance.
REQ-027 SHALL keep sat sticky: set at capture when clamp_hit; cleared by sat_clr; set wins when both occur in the same cycle.
REQ-028 SHALL keep sample_req at 0 in IDLE and STOP.

Reset
REQ-029 SHALL, on rst=1 at a clock edge: state=IDLE, pwm_out=0, sample_req=0, busy=0, sat=0, duty=0, prescale_q=0, prescaler=0, phase=0, pipeline registers=0.
REQ-030 SHALL give rst priority over all other inputs, including mid-period in RUN/STOP; no period completion.
REQ-031 SHALL require that after rst deasserts with en=1 held, RUN is entered on the first clock; the captured duty reflects pipeline contents, which are 0 until 2 cycles have elapsed.

Verification
REQ-032 SHALL cover: gain=255, offset=0, sample=128, prescale=0, en=1 steady -> every 255-clock period has pwm_out high for 128 clocks, with sample_req once per period and sat=0.
REQ-033 SHALL cover: gain=127, sample=200, offset=0 -> duty 100, giving 100 high clocks per 255; then offset=-20 -> duty 80 from the next period start only.
REQ-034 SHALL cover: sample=200, gain=255, offset=+100 -> pwm_out constant high, sat=1; sat_clr pulsed on a capture cycle -> sat stays 1; sat_clr pulsed on a non-capture cycle -> sat=0 until the next capture.
REQ-035 SHALL cover: sample=10, gain=255, offset=-50 -> pwm_out constant low, sat=1.
REQ-036 SHALL cover: prescale=3, duty 64 -> period 1020 clocks, with 256 high clocks; prescale changed to 0 mid-period -> current period still 1020 clocks.
REQ-037 SHALL cover: en dropped at phase 100 -> busy stays 1 until the phase-254 tick and pwm_out then 0; separately, rst at phase 100 -> next cycle pwm_out=0, busy=0, sat=0.

Source files
------------

// File: rtl/wave_pwm_dac.sv
// wave_pwm_dac: gain/offset scaled sample driving a period-synchronous PWM DAC
module wave_pwm_dac #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [7:0]       sample,
  input  logic [7:0]       gain,
  input  logic [7:0]       offset,
  input  logic [DIV_W-1:0] prescale,
  input  logic             sat_clr,
  output logic             pwm_out,
  output logic             sample_req,
  output logic             busy,
  output logic             sat
);
  typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;
  state_t state, nxt_state;
  logic [7:0] scaled_d, scaled, off_q, next_duty, duty, phase, nxt_phase, nxt_duty;
  logic [9:0] sum;
  logic clamp_hit, tick, wrap, start;
  logic [DIV_W-1:0] prescaler, prescale_q, nxt_prescaler;
  assign scaled_d = 8'((16'(sample) * (16'(gain) + 16'd1)) >> 8);
  assign sum = {2'b00, scaled} + {{2{off_q[7]}}, off_q};
  always_ff @(posedge clk) begin
    if (rst) begin
      scaled <= '0;
      off_q <= '0;
      next_duty <= '0;
      clamp_hit <= 1'b0;
    end else begin
      scaled <= scaled_d;
      off_q <= offset;
      next_duty <= sum[9] ? 8'd0 : sum[8] ? 8'hff : sum[7:0];
      clamp_hit <= sum[9] | sum[8];
    end
  end
  always_ff @(posedge clk) state <= rst ? IDLE : nxt_state;
  always_comb begin
    tick = state != IDLE && prescaler == prescale_q;
    wrap = tick && phase == 8'd254;
    nxt_state = state == IDLE ? (en ? RUN : IDLE) :
                en ? RUN : (state == RUN || !wrap) ? STOP : IDLE;
  end
  always_comb begin
    busy = state != IDLE;
    start = state == IDLE ? en : wrap && (state == RUN || en);
    nxt_phase = state == IDLE || wrap ? 8'd0 : tick ? phase + 8'd1 : phase;
    nxt_prescaler = state == IDLE || tick ? '0 : prescaler + DIV_W'(1);
    nxt_duty = start ? next_duty : duty;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      phase <= '0;
      prescaler <= '0;
      prescale_q <= '0;
      duty <= '0;
      sample_req <= 1'b0;
      pwm_out <= 1'b0;
      sat <= 1'b0;
    end else begin
      phase <= nxt_phase;
      prescaler <= nxt_prescaler;
      prescale_q <= start ? prescale : prescale_q;
      duty <= nxt_duty;
      sample_req <= start;
      pwm_out <= nxt_state != IDLE && nxt_phase < nxt_duty;
      sat <= (start && clamp_hit) || (sat && !sat_clr);
    end
  end
endmodule

// File: tb/tb_wave_pwm_dac.sv
// tb_wave_pwm_dac: directed self-checking bench for wave_pwm_dac
module tb_wave_pwm_dac;
  logic clk = 1'b0, rst = 1'b1, en = 1'b0, sat_clr = 1'b0;
  logic [7:0] sample = '0, gain = '0, offset = '0;
  logic [15:0] prescale = '0;
  logic pwm_out, sample_req, busy, sat;
  int checks = 0, errors = 0;
  int len, hi;
  wave_pwm_dac #(.DIV_W(16)) dut (
    .clk(clk), .rst(rst), .en(en), .sample(sample), .gain(gain), .offset(offset),
    .prescale(prescale), .sat_clr(sat_clr), .pwm_out(pwm_out), .sample_req(sample_req),
    .busy(busy), .sat(sat)
  );
  always #5 clk = ~clk;
  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic measure(output int l, output int h);
    int n;
    n = 0;
    while (!sample_req && n < 5000) begin
      @(negedge clk);
      n++;
    end
    l = 0;
    h = 0;
    if (!sample_req) begin
      l = -1;
      return;
    end
    do begin
      h += int'(pwm_out);
      l++;
      @(negedge clk);
    end while (!sample_req && l < 5000);
  endtask
  task automatic test_reset();
    en = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (pwm_out !== 1'b0) begin errors++; $display("FAIL rst_pwm got %b exp 0", pwm_out); end
    checks++; if (sample_req !== 1'b0) begin errors++; $display("FAIL rst_req got %b exp 0", sample_req); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
    checks++; if (sat !== 1'b0) begin errors++; $display("FAIL rst_sat got %b exp 0", sat); end
    en = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_prio_busy got %b exp 0", busy); end
    en = 1'b0;
    rst = 1'b0;
    @(negedge clk);
  endtask
  task automatic test_unity();
    sample = 8'd128; gain = 8'd255; offset = 8'd0; prescale = 16'd0; en = 1'b1;
    do_reset();
    measure(len, hi);
    checks++; if (len !== 255) begin errors++; $display("FAIL unity_p0_len got %0d exp 255", len); end
    checks++; if (hi !== 0) begin errors++; $display("FAIL unity_p0_high got %0d exp 0", hi); end
    for (int p = 1; p <= 2; p++) begin
      measure(len, hi);
      checks++; if (len !== 255) begin errors++; $display("FAIL unity_len p%0d got %0d exp 255", p, len); end
      checks++; if (hi !== 128) begin errors++; $display("FAIL unity_high p%0d got %0d exp 128", p, hi); end
    end
    checks++; if (sat !== 1'b0) begin errors++; $display("FAIL unity_sat got %b exp 0", sat); end
  endtask
  task automatic test_gain_offset();
    sample = 8'd200; gain = 8'd127; offset = 8'd0; prescale = 16'd0; en = 1'b1;
    do_reset();
    measure(len, hi);
    measure(len, hi);
    checks++; if (hi !== 100) begin errors++; $display("FAIL gain_high got %0d exp 100", hi); end
    offset = 8'hEC;
    measure(len, hi);
    checks++; if (hi !== 100) begin errors++; $display("FAIL offset_same_period got %0d exp 100", hi); end
    measure(len, hi);
    checks++; if (hi !== 80) begin errors++; $display("FAIL offset_next_period got %0d exp 80", hi); end
    checks++; if (len !== 255) begin errors++; $display("FAIL offset_len got %0d exp 255", len); end
  endtask
  task automatic test_sat_high();
    int n;
    sample = 8'd200; gain = 8'd255; offset = 8'd100; prescale = 16'd0; en = 1'b1;
    do_reset();
    measure(len, hi);
    measure(len, hi);
    checks++; if (hi !== 255) begin errors++; $display("FAIL sath_high got %0d exp 255", hi); end
    checks++; if (sat !== 1'b1) begin errors++; $display("FAIL sath_sat got %b exp 1", sat); end
    repeat (254) @(negedge clk);
    sat_clr = 1'b1;
    @(negedge clk);
    sat_clr = 1'b0;
    checks++; if (sample_req !== 1'b1) begin errors++; $display("FAIL sath_capture_req got %b exp 1", sample_req); end
    checks++; if (sat !== 1'b1) begin errors++; $display("FAIL sath_clr_on_capture got %b exp 1", sat); end
    sat_clr = 1'b1;
    @(negedge clk);
    sat_clr = 1'b0;
    checks++; if (sat !== 1'b0) begin errors++; $display("FAIL sath_clr got %b exp 0", sat); end
    repeat (100) @(negedge clk);
    checks++; if (sat !== 1'b0) begin errors++; $display("FAIL sath_clr_hold got %b exp 0", sat); end
    n = 0;
    while (!sample_req && n < 1000) begin
      @(negedge clk);
      n++;
    end
    checks++; if (sat !== 1'b1) begin errors++; $display("FAIL sath_reset_on_capture got %b exp 1", sat); end
  endtask
  task automatic test_sat_low();
    sample = 8'd10; gain = 8'd255; offset = 8'hCE; prescale = 16'd0; en = 1'b1;
    do_reset();
    measure(len, hi);
    measure(len, hi);
    checks++; if (len !== 255) begin errors++; $display("FAIL satl_len got %0d exp 255", len); end
    checks++; if (hi !== 0) begin errors++; $display("FAIL satl_high got %0d exp 0", hi); end
    checks++; if (sat !== 1'b1) begin errors++; $display("FAIL satl_sat got %b exp 1", sat); end
  endtask
  task automatic test_prescale();
    sample = 8'd64; gain = 8'd255; offset = 8'd0; prescale = 16'd3; en = 1'b1;
    do_reset();
    measure(len, hi);
    checks++; if (len !== 1020) begin errors++; $display("FAIL pre_p0_len got %0d exp 1020", len); end
    measure(len, hi);
    checks++; if (len !== 1020) begin errors++; $display("FAIL pre_len got %0d exp 1020", len); end
    checks++; if (hi !== 256) begin errors++; $display("FAIL pre_high got %0d exp 256", hi); end
    len = 0;
    hi = 0;
    do begin
      if (len == 100) prescale = 16'd0;
      hi += int'(pwm_out);
      len++;
      @(negedge clk);
    end while (!sample_req && len < 5000);
    checks++; if (len !== 1020) begin errors++; $display("FAIL pre_change_len got %0d exp 1020", len); end
    measure(len, hi);
    checks++; if (len !== 255) begin errors++; $display("FAIL pre_new_len got %0d exp 255", len); end
    checks++; if (hi !== 64) begin errors++; $display("FAIL pre_new_high got %0d exp 64", hi); end
  endtask
  task automatic test_stop();
    int n, h, r;
    sample = 8'd128; gain = 8'd255; offset = 8'd0; prescale = 16'd0; en = 1'b1;
    do_reset();
    measure(len, hi);
    len = 0;
    hi = 0;
    do begin
      if (len == 50) en = 1'b0;
      if (len == 60) en = 1'b1;
      hi += int'(pwm_out);
      len++;
      @(negedge clk);
    end while (!sample_req && len < 5000);
    checks++; if (len !== 255) begin errors++; $display("FAIL resume_len got %0d exp 255", len); end
    checks++; if (hi !== 128) begin errors++; $display("FAIL resume_high got %0d exp 128", hi); end
    repeat (100) @(negedge clk);
    en = 1'b0;
    n = 0; h = 0; r = 0;
    while (busy && n < 1000) begin
      n++;
      h += int'(pwm_out);
      r += int'(sample_req);
      @(negedge clk);
    end
    checks++; if (n !== 155) begin errors++; $display("FAIL stop_busy_cycles got %0d exp 155", n); end
    checks++; if (h !== 28) begin errors++; $display("FAIL stop_high got %0d exp 28", h); end
    checks++; if (r !== 0) begin errors++; $display("FAIL stop_req got %0d exp 0", r); end
    checks++; if (pwm_out !== 1'b0) begin errors++; $display("FAIL stop_idle_pwm got %b exp 0", pwm_out); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stop_idle_busy got %b exp 0", busy); end
  endtask
  task automatic test_rst_mid();
    sample = 8'd200; gain = 8'd255; offset = 8'd100; prescale = 16'd0; en = 1'b1;
    do_reset();
    measure(len, hi);
    measure(len, hi);
    repeat (100) @(negedge clk);
    checks++; if (pwm_out !== 1'b1 || sat !== 1'b1) begin errors++; $display("FAIL rstmid_pre got pwm=%b sat=%b exp 1 1", pwm_out, sat); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (pwm_out !== 1'b0) begin errors++; $display("FAIL rstmid_pwm got %b exp 0", pwm_out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b exp 0", busy); end
    checks++; if (sat !== 1'b0) begin errors++; $display("FAIL rstmid_sat got %b exp 0", sat); end
    rst = 1'b0;
    en = 1'b0;
    @(negedge clk);
  endtask
  initial begin
    @(negedge clk);
    test_reset();
    test_unity();
    test_gain_offset();
    test_sat_high();
    test_sat_low();
    test_prescale();
    test_stop();
    test_rst_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
